// File: rtl/rob_commit.sv
// In-order retirement buffer: dual enqueue, dual out-of-order completion, dual in-order retire to the register file.
// Optional ROB_PERF_EN adds commit_count and stall_cycles performance counters.
module rob_commit #(
  parameter int OPRAND_WIDTH  = 16,
  parameter int REGNAME_WIDTH = 5,
  parameter int ROB_DEPTH     = 8,
  parameter int TAG_WIDTH     = $clog2(ROB_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq1_en,
  input  logic                     enq2_en,
  input  logic                     enq1_has_dest,
  input  logic                     enq2_has_dest,
  input  logic [REGNAME_WIDTH-1:0] enq1_dest,
  input  logic [REGNAME_WIDTH-1:0] enq2_dest,
  output logic                     enq_ready,
  output logic [TAG_WIDTH-1:0]     enq1_tag,
  output logic [TAG_WIDTH-1:0]     enq2_tag,
  input  logic                     cmp1_en,
  input  logic                     cmp2_en,
  input  logic [TAG_WIDTH-1:0]     cmp1_tag,
  input  logic [TAG_WIDTH-1:0]     cmp2_tag,
  input  logic [OPRAND_WIDTH-1:0]  cmp1_data,
  input  logic [OPRAND_WIDTH-1:0]  cmp2_data,
  output logic                     WB_en1,
  output logic                     WB_en2,
  output logic [REGNAME_WIDTH-1:0] WB_target1,
  output logic [REGNAME_WIDTH-1:0] WB_target2,
  output logic [OPRAND_WIDTH-1:0]  WB_data1,
  output logic [OPRAND_WIDTH-1:0]  WB_data2,
  output logic                     empty
`ifdef ROB_PERF_EN
  ,
  output logic [31:0]              commit_count,
  output logic [31:0]              stall_cycles
`endif
);

  localparam logic [TAG_WIDTH:0] READY_MAX = (TAG_WIDTH+1)'(ROB_DEPTH - 2);

  logic [ROB_DEPTH-1:0]     busy;
  logic [ROB_DEPTH-1:0]     done;
  logic [ROB_DEPTH-1:0]     has_dest;
  logic [REGNAME_WIDTH-1:0] dest_q [ROB_DEPTH];
  logic [OPRAND_WIDTH-1:0]  data_q [ROB_DEPTH];
  logic [TAG_WIDTH-1:0]     head;
  logic [TAG_WIDTH-1:0]     tail;
  logic [TAG_WIDTH:0]       count;

  logic [TAG_WIDTH-1:0] head_nx;
  logic [TAG_WIDTH-1:0] tail_nx;
  logic                 ret1;
  logic                 ret2;
  logic                 do_enq1;
  logic                 do_enq2;
  logic [TAG_WIDTH:0]   enq_cnt;
  logic [TAG_WIDTH:0]   ret_cnt;

  assign enq_ready = (count <= READY_MAX);
  assign empty     = (count == '0);
  assign enq1_tag  = tail;
  assign enq2_tag  = tail_nx;

  always_comb begin
    head_nx = head + TAG_WIDTH'(1);
    tail_nx = tail + TAG_WIDTH'(1);
    ret1    = busy[head] & done[head];
    ret2    = ret1 & busy[head_nx] & done[head_nx];
    do_enq1 = enq1_en & enq_ready;
    do_enq2 = do_enq1 & enq2_en;
    enq_cnt = (TAG_WIDTH+1)'(do_enq1) + (TAG_WIDTH+1)'(do_enq2);
    ret_cnt = (TAG_WIDTH+1)'(ret1) + (TAG_WIDTH+1)'(ret2);
  end

  // Order matters: completion, then retire clears busy, then enqueue claims free slots.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      done       <= '0;
      has_dest   <= '0;
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      WB_en1     <= 1'b0;
      WB_en2     <= 1'b0;
      WB_target1 <= '0;
      WB_target2 <= '0;
      WB_data1   <= '0;
      WB_data2   <= '0;
    end else if (flush) begin
      busy   <= '0;
      done   <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      WB_en1 <= 1'b0;
      WB_en2 <= 1'b0;
    end else begin
      if (cmp1_en && busy[cmp1_tag]) begin
        done[cmp1_tag]   <= 1'b1;
        data_q[cmp1_tag] <= cmp1_data;
      end
      if (cmp2_en && busy[cmp2_tag]) begin
        done[cmp2_tag]   <= 1'b1;
        data_q[cmp2_tag] <= cmp2_data;
      end
      if (ret1) busy[head]    <= 1'b0;
      if (ret2) busy[head_nx] <= 1'b0;
      if (do_enq1) begin
        busy[tail]     <= 1'b1;
        done[tail]     <= 1'b0;
        has_dest[tail] <= enq1_has_dest;
        dest_q[tail]   <= enq1_dest;
      end
      if (do_enq2) begin
        busy[tail_nx]     <= 1'b1;
        done[tail_nx]     <= 1'b0;
        has_dest[tail_nx] <= enq2_has_dest;
        dest_q[tail_nx]   <= enq2_dest;
      end
      head   <= head + ret_cnt[TAG_WIDTH-1:0];
      tail   <= tail + enq_cnt[TAG_WIDTH-1:0];
      count  <= count + enq_cnt - ret_cnt;
      WB_en1 <= ret1 & has_dest[head];
      WB_en2 <= ret2 & has_dest[head_nx];
      if (ret1) begin
        WB_target1 <= dest_q[head];
        WB_data1   <= data_q[head];
      end
      if (ret2) begin
        WB_target2 <= dest_q[head_nx];
        WB_data2   <= data_q[head_nx];
      end
    end
  end

`ifdef ROB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_count <= '0;
      stall_cycles <= '0;
    end else begin
      if (!flush) commit_count <= commit_count + 32'(ret_cnt);
      if (enq1_en && !enq_ready) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: per-cycle vector table plus a hand-written asynchronous reset sequence.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        enq1_en, enq2_en, enq1_has_dest, enq2_has_dest;
  logic [4:0]  enq1_dest, enq2_dest;
  logic        enq_ready;
  logic [2:0]  enq1_tag, enq2_tag;
  logic        cmp1_en, cmp2_en;
  logic [2:0]  cmp1_tag, cmp2_tag;
  logic [15:0] cmp1_data, cmp2_data;
  logic        WB_en1, WB_en2;
  logic [4:0]  WB_target1, WB_target2;
  logic [15:0] WB_data1, WB_data2;
  logic        empty;

  int checks = 0;
  int failures = 0;

  rob_commit #(.OPRAND_WIDTH(16), .REGNAME_WIDTH(5), .ROB_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq1_en(enq1_en), .enq2_en(enq2_en),
    .enq1_has_dest(enq1_has_dest), .enq2_has_dest(enq2_has_dest),
    .enq1_dest(enq1_dest), .enq2_dest(enq2_dest),
    .enq_ready(enq_ready), .enq1_tag(enq1_tag), .enq2_tag(enq2_tag),
    .cmp1_en(cmp1_en), .cmp2_en(cmp2_en),
    .cmp1_tag(cmp1_tag), .cmp2_tag(cmp2_tag),
    .cmp1_data(cmp1_data), .cmp2_data(cmp2_data),
    .WB_en1(WB_en1), .WB_en2(WB_en2),
    .WB_target1(WB_target1), .WB_target2(WB_target2),
    .WB_data1(WB_data1), .WB_data2(WB_data2),
    .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        e1, e2, h1, h2;
    logic [4:0]  d1, d2;
    logic        c1;
    logic [2:0]  ct1;
    logic [15:0] cd1;
    logic        c2;
    logic [2:0]  ct2;
    logic [15:0] cd2;
    logic        fl;
    logic        x1, x2;
    logic [4:0]  xt1, xt2;
    logic [15:0] xd1, xd2;
    logic        xr, xe;
    logic [2:0]  xtag;
  } vec_t;

  vec_t vq[$];

  // Expected values describe the outputs just after the edge that consumed the vector's inputs.
  function automatic void push(
    input logic e1, e2, h1, h2, input logic [4:0] d1, d2,
    input logic c1, input logic [2:0] ct1, input logic [15:0] cd1,
    input logic c2, input logic [2:0] ct2, input logic [15:0] cd2,
    input logic fl, input logic x1, x2, input logic [4:0] xt1, xt2,
    input logic [15:0] xd1, xd2, input logic xr, xe, input logic [2:0] xtag);
    vq.push_back('{e1, e2, h1, h2, d1, d2, c1, ct1, cd1, c2, ct2, cd2, fl,
                   x1, x2, xt1, xt2, xd1, xd2, xr, xe, xtag});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; enq1_en = 0; enq2_en = 0; enq1_has_dest = 0; enq2_has_dest = 0;
    enq1_dest = 0; enq2_dest = 0; cmp1_en = 0; cmp2_en = 0;
    cmp1_tag = 0; cmp2_tag = 0; cmp1_data = 0; cmp2_data = 0;
  endtask

  initial begin
    logic [2:0] xtag2;
    //   e1 e2 h1 h2 d1  d2   c1 ct1 cd1      c2 ct2 cd2     fl  x1 x2 t1  t2  xd1      xd2      rdy emp tag
    push(1, 1, 1, 1, 3,  4,   0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  0,  2);
    push(0, 0, 0, 0, 0,  0,   1, 1, 16'h00BB, 0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  0,  2);
    push(0, 0, 0, 0, 0,  0,   1, 0, 16'h00AA, 0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  0,  2);
    push(0, 0, 0, 0, 0,  0,   0, 0, 16'h0,    0, 0, 16'h0,   0,  1, 1, 3,  4,  16'h00AA,16'h00BB,1,  1,  2);
    push(0, 0, 0, 0, 0,  0,   0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  1,  2);
    // younger completes first; nothing retires until the head completes
    push(1, 1, 1, 1, 6,  7,   0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  0,  4);
    push(0, 0, 0, 0, 0,  0,   1, 3, 16'h0033, 0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  0,  4);
    push(0, 0, 0, 0, 0,  0,   0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  0,  4);
    push(0, 0, 0, 0, 0,  0,   1, 2, 16'h0022, 0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  0,  4);
    push(0, 0, 0, 0, 0,  0,   0, 0, 16'h0,    0, 0, 16'h0,   0,  1, 1, 6,  7,  16'h0022,16'h0033,1,  1,  4);
    push(0, 0, 0, 0, 0,  0,   0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  1,  4);
    // fill to 7 with wrap, then retire two and reuse tags
    push(1, 1, 1, 1, 8,  9,   0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  0,  6);
    push(1, 1, 1, 1, 10, 11,  0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  0,  0);
    push(1, 1, 1, 1, 12, 13,  0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  0,  2);
    push(1, 0, 1, 0, 14, 0,   0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   0,  0,  3);
    push(0, 0, 0, 0, 0,  0,   1, 4, 16'h0044, 1, 5, 16'h0055,0,  0, 0, 0,  0,  16'h0,   16'h0,   0,  0,  3);
    push(0, 0, 0, 0, 0,  0,   0, 0, 16'h0,    0, 0, 16'h0,   0,  1, 1, 8,  9,  16'h0044,16'h0055,1,  0,  3);
    push(1, 1, 1, 1, 15, 16,  0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   0,  0,  5);
    push(0, 0, 0, 0, 0,  0,   1, 6, 16'h0066, 1, 7, 16'h0077,0,  0, 0, 0,  0,  16'h0,   16'h0,   0,  0,  5);
    push(0, 0, 0, 0, 0,  0,   0, 0, 16'h0,    0, 0, 16'h0,   0,  1, 1, 10, 11, 16'h0066,16'h0077,1,  0,  5);
    // flush with 5 busy and a completion to the head in the same cycle
    push(0, 0, 0, 0, 0,  0,   1, 0, 16'h1234, 0, 0, 16'h0,   1,  0, 0, 0,  0,  16'h0,   16'h0,   1,  1,  0);
    push(0, 0, 0, 0, 0,  0,   0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  1,  0);
    // same destination in both slots
    push(1, 1, 1, 1, 5,  5,   0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  0,  2);
    push(0, 0, 0, 0, 0,  0,   1, 0, 16'h1111, 1, 1, 16'h2222,0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  0,  2);
    push(0, 0, 0, 0, 0,  0,   0, 0, 16'h0,    0, 0, 16'h0,   0,  1, 1, 5,  5,  16'h1111,16'h2222,1,  1,  2);
    push(0, 0, 0, 0, 0,  0,   0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  1,  2);
    // no-dest head, same-tag completion on both ports (port 2 wins)
    push(1, 1, 0, 1, 9,  20,  0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  0,  4);
    push(0, 0, 0, 0, 0,  0,   1, 3, 16'hAAAA, 1, 3, 16'hBBBB,0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  0,  4);
    push(0, 0, 0, 0, 0,  0,   1, 2, 16'h0009, 0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  0,  4);
    push(0, 0, 0, 0, 0,  0,   0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 1, 0,  20, 16'h0,   16'hBBBB,1,  1,  4);
    push(0, 0, 0, 0, 0,  0,   0, 0, 16'h0,    0, 0, 16'h0,   0,  0, 0, 0,  0,  16'h0,   16'h0,   1,  1,  4);

    idle_inputs();
    rst = 0;
    repeat (2) @(negedge clk);
    chk("reset WB_en1", WB_en1, 0);
    chk("reset WB_en2", WB_en2, 0);
    chk("reset WB_target1", WB_target1, 0);
    chk("reset WB_data2", WB_data2, 0);
    chk("reset enq_ready", enq_ready, 1);
    chk("reset empty", empty, 1);
    chk("reset enq1_tag", enq1_tag, 0);
    rst = 1;

    foreach (vq[i]) begin
      @(negedge clk);
      flush = vq[i].fl;
      enq1_en = vq[i].e1; enq2_en = vq[i].e2;
      enq1_has_dest = vq[i].h1; enq2_has_dest = vq[i].h2;
      enq1_dest = vq[i].d1; enq2_dest = vq[i].d2;
      cmp1_en = vq[i].c1; cmp1_tag = vq[i].ct1; cmp1_data = vq[i].cd1;
      cmp2_en = vq[i].c2; cmp2_tag = vq[i].ct2; cmp2_data = vq[i].cd2;
      if (vq[i].e1 && !enq_ready) begin
        checks++;
        failures++;
        $display("FAIL v%0d enq_protocol: enqueue offered with enq_ready=0", i);
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d WB_en1", i), WB_en1, vq[i].x1);
      chk($sformatf("v%0d WB_en2", i), WB_en2, vq[i].x2);
      if (vq[i].x1) begin
        chk($sformatf("v%0d WB_target1", i), WB_target1, vq[i].xt1);
        chk($sformatf("v%0d WB_data1", i), WB_data1, vq[i].xd1);
      end
      if (vq[i].x2) begin
        chk($sformatf("v%0d WB_target2", i), WB_target2, vq[i].xt2);
        chk($sformatf("v%0d WB_data2", i), WB_data2, vq[i].xd2);
      end
      chk($sformatf("v%0d enq_ready", i), enq_ready, vq[i].xr);
      chk($sformatf("v%0d empty", i), empty, vq[i].xe);
      chk($sformatf("v%0d enq1_tag", i), enq1_tag, vq[i].xtag);
      xtag2 = vq[i].xtag + 3'd1;
      chk($sformatf("v%0d enq2_tag", i), enq2_tag, xtag2);
    end

    // Asynchronous reset between completion and the retire edge suppresses the write-back.
    @(negedge clk);
    idle_inputs();
    enq1_en = 1; enq2_en = 1; enq1_has_dest = 1; enq2_has_dest = 1;
    enq1_dest = 7; enq2_dest = 8;
    @(negedge clk);
    idle_inputs();
    cmp1_en = 1; cmp1_tag = 4; cmp1_data = 16'h0E0E;
    cmp2_en = 1; cmp2_tag = 5; cmp2_data = 16'h0F0F;
    @(posedge clk);
    #2;
    idle_inputs();
    rst = 0;
    #1;
    chk("async_rst empty", empty, 1);
    chk("async_rst enq1_tag", enq1_tag, 0);
    chk("async_rst WB_en1", WB_en1, 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("post_rst WB_en1", WB_en1, 0);
    chk("post_rst WB_en2", WB_en2, 0);
    chk("post_rst empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
